// File: rtl/led_matrix_scanner_if.sv
// Frame transfer bus for led_matrix_scanner.
// The producer (master) offers a red/green frame pair with frameValid.
// The scanner (slave) returns frameReady.
//   redFrame   : red pixels, pixel(r,c) = bit r*COLS+c
//   greenFrame : green pixels, same layout
//   frameValid : producer offers a frame
//   frameReady : scanner pending buffer is empty
interface led_matrix_scanner_if #(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 8
);
  logic [ROWS*COLS-1:0] redFrame;
  logic [ROWS*COLS-1:0] greenFrame;
  logic                 frameValid;
  logic                 frameReady;

  modport master (output redFrame, output greenFrame, output frameValid, input frameReady);
  modport slave  (input redFrame, input greenFrame, input frameValid, output frameReady);
endinterface

// File: rtl/led_matrix_scanner.sv
// Double-buffered bicolour LED-matrix row scanner.
// Each row gets a slot of DWELL cycles. The first BLANK cycles of a slot
// are dark to suppress ghosting. New frames land in a pending buffer and
// are swapped into the display buffer only at a frame boundary.
// Optional feature macro: BRIGHTNESS_PWM_EN adds a 4-bit brightness port
// that PWMs the column drivers in 16 subslots of the DRIVE phase.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   frameBus     : frame handshake (led_matrix_scanner_if.slave)
//   mode         : 00 red, 01 green, 10 both, 11 blank
//   brightness   : global brightness (BRIGHTNESS_PWM_EN only)
//   rowSink      : one-hot row select, polarity set by ROW_ACTIVE_LOW
//   redDriver    : red column drive, 1 = lit
//   greenDriver  : green column drive, 1 = lit
//   frameStart   : pulse in the first output cycle of row 0
module led_matrix_scanner #(
  parameter int unsigned ROWS           = 8,
  parameter int unsigned COLS           = 8,
  parameter int unsigned DWELL          = 32768,
  parameter int unsigned BLANK          = 64,
  parameter int unsigned ROW_ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  led_matrix_scanner_if.slave frameBus,
  input  logic [1:0]          mode,
`ifdef BRIGHTNESS_PWM_EN
  input  logic [3:0]          brightness,
`endif
  output logic [ROWS-1:0]     rowSink,
  output logic [COLS-1:0]     redDriver,
  output logic [COLS-1:0]     greenDriver,
  output logic                frameStart
);

  localparam int unsigned PIX   = ROWS * COLS;
  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  // Level of every row pin when no row is selected.
  localparam logic [ROWS-1:0] ROWS_OFF = {ROWS{(ROW_ACTIVE_LOW != 0)}};

  logic [CNT_W-1:0] slotCnt;
  logic [ROW_W-1:0] rowIdx;
  logic [PIX-1:0]   dispRed;
  logic [PIX-1:0]   dispGreen;
  logic [PIX-1:0]   pendRed;
  logic [PIX-1:0]   pendGreen;
  logic             pendFull;

  logic             slotEnd;
  logic             frameEnd;
  logic             inBlank;
  logic             take;
  logic             drvOn;
  logic [ROWS-1:0]  rowSel;
  logic [COLS-1:0]  redRow;
  logic [COLS-1:0]  greenRow;
  logic [ROWS-1:0]  rowSinkNxt;
  logic [COLS-1:0]  redNxt;
  logic [COLS-1:0]  greenNxt;

  // Slot timing and handshake qualifiers.
  always_comb begin
    slotEnd  = (slotCnt == CNT_W'(DWELL - 1));
    frameEnd = slotEnd && (rowIdx == ROW_W'(ROWS - 1));
    inBlank  = (slotCnt < CNT_W'(BLANK));
    take     = frameBus.frameValid && frameBus.frameReady;
  end

  // Decode the current row and pick its pixels from the display buffer.
  always_comb begin
    rowSel   = '0;
    redRow   = '0;
    greenRow = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (rowIdx == ROW_W'(r)) begin
        rowSel[r] = 1'b1;
        redRow    = dispRed[r*COLS +: COLS];
        greenRow  = dispGreen[r*COLS +: COLS];
      end
    end
  end

`ifdef BRIGHTNESS_PWM_EN
  localparam int unsigned SUB   = (DWELL - BLANK) / 16;
  localparam int unsigned SUB_W = (SUB > 1) ? $clog2(SUB) : 1;

  logic [SUB_W-1:0] subCnt;
  logic [3:0]       subIdx;
  logic [3:0]       bLat;

  // Subslot tracker; brightness is frozen for the whole slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      subCnt <= '0;
      subIdx <= '0;
      bLat   <= '0;
    end else begin
      if (slotCnt == '0) bLat <= brightness;
      if (inBlank) begin
        subCnt <= '0;
        subIdx <= '0;
      end else if (subCnt == SUB_W'(SUB - 1)) begin
        subCnt <= '0;
        subIdx <= subIdx + 4'd1;
      end else begin
        subCnt <= subCnt + SUB_W'(1);
      end
    end
  end

  assign drvOn = !inBlank && (subIdx < bLat);
`else
  assign drvOn = !inBlank;
`endif

  // Next output values; XOR with ROWS_OFF applies the row polarity.
  always_comb begin
    rowSinkNxt = ROWS_OFF;
    redNxt     = '0;
    greenNxt   = '0;
    if (!inBlank) rowSinkNxt = ROWS_OFF ^ rowSel;
    if (drvOn) begin
      redNxt   = (mode == 2'b00 || mode == 2'b10) ? redRow : '0;
      greenNxt = (mode == 2'b01 || mode == 2'b10) ? greenRow : '0;
    end
  end

  // Scan counters, frame buffers and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slotCnt             <= '0;
      rowIdx              <= '0;
      dispRed             <= '0;
      dispGreen           <= '0;
      pendRed             <= '0;
      pendGreen           <= '0;
      pendFull            <= 1'b0;
      frameBus.frameReady <= 1'b1;
      rowSink             <= ROWS_OFF;
      redDriver           <= '0;
      greenDriver         <= '0;
      frameStart          <= 1'b0;
    end else begin
      if (slotEnd) begin
        slotCnt <= '0;
        rowIdx  <= (rowIdx == ROW_W'(ROWS - 1)) ? '0 : rowIdx + ROW_W'(1);
      end else begin
        slotCnt <= slotCnt + CNT_W'(1);
      end

      // Ready is low while pending is full, so swap and take never coincide.
      if (frameEnd && pendFull) begin
        dispRed             <= pendRed;
        dispGreen           <= pendGreen;
        pendFull            <= 1'b0;
        frameBus.frameReady <= 1'b1;
      end else if (take) begin
        pendRed             <= frameBus.redFrame;
        pendGreen           <= frameBus.greenFrame;
        pendFull            <= 1'b1;
        frameBus.frameReady <= 1'b0;
      end

      rowSink     <= rowSinkNxt;
      redDriver   <= redNxt;
      greenDriver <= greenNxt;
      frameStart  <= (slotCnt == '0) && (rowIdx == '0);
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench for led_matrix_scanner (ROWS=4, COLS=4, DWELL=36, BLANK=4).
// The driver computes each cycle's expected outputs from the elapsed cycle
// count since reset and a frame-level buffer model, and queues them.
// The monitor pops and compares after every clock edge. It also checks
// reset values while reset_n is low.
module tb_led_matrix_scanner;

  localparam int unsigned ROWS   = 4;
  localparam int unsigned COLS   = 4;
  localparam int unsigned DWELL  = 36;
  localparam int unsigned BLANK  = 4;
  localparam int unsigned PIX    = ROWS * COLS;
  localparam int unsigned PERIOD = ROWS * DWELL;
  localparam logic [ROWS-1:0] ALL_OFF = {ROWS{1'b1}};

  typedef struct {
    logic [ROWS-1:0] rowSink;
    logic [COLS-1:0] red;
    logic [COLS-1:0] green;
    logic            frameStart;
    logic            frameReady;
  } exp_t;

  logic            clk;
  logic            reset_n;
  logic [1:0]      mode;
  logic [ROWS-1:0] rowSink;
  logic [COLS-1:0] redDriver;
  logic [COLS-1:0] greenDriver;
  logic            frameStart;
`ifdef BRIGHTNESS_PWM_EN
  logic [3:0]      brightness;
  logic [3:0]      curBright;
  logic [3:0]      mBLat;
`endif

  led_matrix_scanner_if #(.ROWS(ROWS), .COLS(COLS)) frameBus ();

  led_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .BLANK(BLANK), .ROW_ACTIVE_LOW(1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frameBus   (frameBus),
    .mode       (mode),
`ifdef BRIGHTNESS_PWM_EN
    .brightness (brightness),
`endif
    .rowSink    (rowSink),
    .redDriver  (redDriver),
    .greenDriver(greenDriver),
    .frameStart (frameStart)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t        expQ[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  // Producer state and reference model.
  logic             offerValid;
  logic [PIX-1:0]   offerR;
  logic [PIX-1:0]   offerG;
  logic [1:0]       curMode;
  int unsigned      n;
  logic [PIX-1:0]   mDispR;
  logic [PIX-1:0]   mDispG;
  logic [PIX-1:0]   mPendR;
  logic [PIX-1:0]   mPendG;
  logic             mPendFull;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: sampled 1 unit after each falling clock edge or reset assertion.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or negedge reset_n);
      #1;
      if (!reset_n) begin
        chk("rst_rowSink", 32'(rowSink), 32'(ALL_OFF));
        chk("rst_red", 32'(redDriver), 32'd0);
        chk("rst_green", 32'(greenDriver), 32'd0);
        chk("rst_frameStart", 32'(frameStart), 32'd0);
        chk("rst_frameReady", 32'(frameBus.frameReady), 32'd1);
      end else if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("rowSink", 32'(rowSink), 32'(e.rowSink));
        chk("redDriver", 32'(redDriver), 32'(e.red));
        chk("greenDriver", 32'(greenDriver), 32'(e.green));
        chk("frameStart", 32'(frameStart), 32'(e.frameStart));
        chk("frameReady", 32'(frameBus.frameReady), 32'(e.frameReady));
      end
    end
  end

  task automatic modelReset();
    n         = 0;
    mDispR    = '0;
    mDispG    = '0;
    mPendR    = '0;
    mPendG    = '0;
    mPendFull = 1'b0;
`ifdef BRIGHTNESS_PWM_EN
    mBLat     = '0;
`endif
  endtask

  // One clock: drive inputs, predict the outputs after the coming edge,
  // advance the model, then wait to the next falling edge + 2.
  task automatic step(output bit accepted);
    exp_t            e;
    int unsigned     slot;
    int unsigned     row;
    logic [ROWS-1:0] one;
    logic [COLS-1:0] rb;
    logic [COLS-1:0] gb;
    bit              on;
    bit              swap;
    frameBus.frameValid = offerValid;
    frameBus.redFrame   = offerR;
    frameBus.greenFrame = offerG;
    mode                = curMode;
`ifdef BRIGHTNESS_PWM_EN
    brightness          = curBright;
`endif
    slot         = n % DWELL;
    row          = (n / DWELL) % ROWS;
    e.frameStart = ((n % PERIOD) == 0);
    e.rowSink    = ALL_OFF;
    e.red        = '0;
    e.green      = '0;
    if (slot >= BLANK) begin
      one       = ROWS'(1);
      one       = one << row;
      e.rowSink = ~one;
      rb        = mDispR[row*COLS +: COLS];
      gb        = mDispG[row*COLS +: COLS];
      on        = 1'b1;
`ifdef BRIGHTNESS_PWM_EN
      on = ((slot - BLANK) / ((DWELL - BLANK) / 16)) < 32'(mBLat);
`endif
      if (on) begin
        if (curMode == 2'd0 || curMode == 2'd2) e.red = rb;
        if (curMode == 2'd1 || curMode == 2'd2) e.green = gb;
      end
    end
    swap     = ((n % PERIOD) == PERIOD - 1) && mPendFull;
    accepted = offerValid && !mPendFull;
    if (swap) begin
      mDispR    = mPendR;
      mDispG    = mPendG;
      mPendFull = 1'b0;
    end else if (accepted) begin
      mPendR    = offerR;
      mPendG    = offerG;
      mPendFull = 1'b1;
    end
    e.frameReady = !mPendFull;
`ifdef BRIGHTNESS_PWM_EN
    if (slot == 0) mBLat = curBright;
`endif
    n++;
    expQ.push_back(e);
    @(negedge clk);
    #2;
  endtask

  task automatic idle(input int unsigned cycles);
    bit acc;
    for (int unsigned i = 0; i < cycles; i++) begin
      step(acc);
      if (acc) offerValid = 1'b0;
    end
  endtask

  // Offer a frame and hold it until the model says it was taken.
  task automatic offer(input logic [PIX-1:0] r, input logic [PIX-1:0] g);
    bit acc;
    offerR     = r;
    offerG     = g;
    offerValid = 1'b1;
    for (int unsigned i = 0; i < 2 * PERIOD && offerValid; i++) begin
      step(acc);
      if (acc) offerValid = 1'b0;
    end
  endtask

  task automatic runRandom(input int unsigned cycles);
    bit acc;
    for (int unsigned i = 0; i < cycles; i++) begin
      if ($urandom_range(0, 39) == 0) curMode = 2'($urandom_range(0, 3));
`ifdef BRIGHTNESS_PWM_EN
      if ($urandom_range(0, 59) == 0) curBright = 4'($urandom_range(0, 15));
`endif
      if (!offerValid) begin
        offerR = PIX'($urandom);
        offerG = PIX'($urandom);
        if ($urandom_range(0, 29) == 0) offerValid = 1'b1;
      end
      step(acc);
      if (acc) offerValid = 1'b0;
    end
  endtask

  initial begin : driver
    reset_n             = 1'b0;
    curMode             = 2'b00;
    mode                = 2'b00;
    offerValid          = 1'b0;
    offerR              = '0;
    offerG              = '0;
    frameBus.frameValid = 1'b0;
    frameBus.redFrame   = '0;
    frameBus.greenFrame = '0;
`ifdef BRIGHTNESS_PWM_EN
    curBright  = 4'd15;
    brightness = 4'd15;
`endif
    modelReset();
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b1;

    // Empty display for just over one frame: blank/drive phases, frameStart.
    idle(PERIOD + 6);
    // Diagonal red frame, then a second frame offered while pending is full.
    offer(16'h8421, 16'h0000);
    offer(16'h8421, 16'hFFFF);
    idle(2 * PERIOD);
    curMode = 2'b10;
    idle(PERIOD);
    curMode = 2'b11;
    idle(PERIOD);
    curMode = 2'b01;
    idle(PERIOD);

    runRandom(2000);

    // Reset in the DRIVE phase of row 2 with a non-empty display.
    curMode = 2'b10;
    offer(16'hFFFF, 16'hA5A5);
    for (int unsigned i = 0; i < 3 * PERIOD; i++) begin
      if (((n / DWELL) % ROWS) == 2 && (n % DWELL) == 20 && mDispR != '0) break;
      idle(1);
    end
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    modelReset();
    reset_n = 1'b1;
    idle(PERIOD + 10);
    runRandom(400);

`ifdef BRIGHTNESS_PWM_EN
    curMode   = 2'b00;
    curBright = 4'd8;
    offer(16'hFFFF, 16'h0000);
    idle(2 * PERIOD);
    curBright = 4'd0;
    idle(PERIOD);
`endif

    @(negedge clk);
    @(negedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
